alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_flags.sv | 24 ++
 rtl/alu_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU: opcode encoding,
// flag bit positions and controller states.
package alu_seq_pkg;

    localparam int ALUOP_BITS = 4;

    typedef enum logic [ALUOP_BITS-1:0] {
        OP_SELA = 4'd0,
        OP_SELB = 4'd1,
        OP_ADD  = 4'd2,
        OP_ADC  = 4'd3,
        OP_SUB  = 4'd4,
        OP_SBB  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_SAR  = 4'd11,
        OP_MUL  = 4'd12
    } alu_op_t;

    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_SF = 3;
    localparam int FLAG_OF = 4;
    localparam int FLAG_BITS = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_flags.sv
// Combinational result-derived flags (ZF, SF, PF) for a WIDTH-bit result;
// PF follows the x86 rule: set when the low byte has an even number of ones.
module alu_flags #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] result_i,
    output logic             zf_o,
    output logic             sf_o,
    output logic             pf_o
);

    logic [8:0] par_chain;

    assign par_chain[0] = 1'b1;

    for (genvar gi = 0; gi < 8; gi++) begin : g_par
        assign par_chain[gi+1] = par_chain[gi] ^ result_i[gi];
    end

    assign zf_o = (result_i == '0);
    assign sf_o = result_i[WIDTH-1];
    assign pf_o = par_chain[8];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, iterative shifts and an
// iterative shift-add unsigned multiply behind a start/busy/done handshake.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ALUOP_BITS-1:0] op,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  carry_in,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      out,
    output logic [WIDTH-1:0]      out_hi,
    output logic [FLAG_BITS-1:0]  flags,
    output logic                  invalid
);

    localparam int CNT_W = ($clog2(WIDTH + 1) > 5) ? $clog2(WIDTH + 1) : 5;

    alu_state_t           state_q, state_d;
    alu_op_t              op_q, op_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 one_q, one_d;
    logic                 msb_q, msb_d;
    logic                 cf_q, cf_d;

    logic [WIDTH-1:0]     out_q, out_hi_q;
    logic [FLAG_BITS-1:0] flags_q, flags_d;
    logic                 done_q, invalid_q;

    logic                 fin_en;
    logic [WIDTH-1:0]     fin_res;
    logic [WIDTH-1:0]     fin_hi;
    logic                 fin_cf;
    logic                 fin_of;
    logic                 fin_inv;

    logic [WIDTH:0]       arith_w;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH-1:0]     step_work;
    logic [WIDTH-1:0]     step_hi;
    logic                 step_cf;
    logic                 fl_zf, fl_sf, fl_pf;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        hi_d      = hi_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        one_d     = one_q;
        msb_d     = msb_q;
        cf_d      = cf_q;
        fin_en    = 1'b0;
        fin_res   = '0;
        fin_hi    = '0;
        fin_cf    = 1'b0;
        fin_of    = 1'b0;
        fin_inv   = 1'b0;
        arith_w   = '0;
        mul_sum   = '0;
        step_work = work_q;
        step_hi   = hi_q;
        step_cf   = cf_q;

        if (state_q == ST_IDLE) begin
            if (start) begin
                case (op)
                    OP_SELA: begin
                        fin_en  = 1'b1;
                        fin_res = a;
                    end
                    OP_SELB: begin
                        fin_en  = 1'b1;
                        fin_res = b;
                    end
                    OP_ADD, OP_ADC: begin
                        arith_w = {1'b0, a} + {1'b0, b}
                                + {{WIDTH{1'b0}}, (op == OP_ADC) & carry_in};
                        fin_en  = 1'b1;
                        fin_res = arith_w[WIDTH-1:0];
                        fin_cf  = arith_w[WIDTH];
                        fin_of  = (a[WIDTH-1] == b[WIDTH-1]) &&
                                  (arith_w[WIDTH-1] != a[WIDTH-1]);
                    end
                    OP_SUB, OP_SBB: begin
                        // Top bit of the zero-extended difference is the borrow.
                        arith_w = {1'b0, a} - {1'b0, b}
                                - {{WIDTH{1'b0}}, (op == OP_SBB) & carry_in};
                        fin_en  = 1'b1;
                        fin_res = arith_w[WIDTH-1:0];
                        fin_cf  = arith_w[WIDTH];
                        fin_of  = (a[WIDTH-1] != b[WIDTH-1]) &&
                                  (arith_w[WIDTH-1] != a[WIDTH-1]);
                    end
                    OP_AND: begin
                        fin_en  = 1'b1;
                        fin_res = a & b;
                    end
                    OP_OR: begin
                        fin_en  = 1'b1;
                        fin_res = a | b;
                    end
                    OP_XOR: begin
                        fin_en  = 1'b1;
                        fin_res = a ^ b;
                    end
                    OP_SHL, OP_SHR, OP_SAR: begin
                        if (b[4:0] == 5'd0) begin
                            fin_en  = 1'b1;
                            fin_res = a;
                        end else begin
                            state_d = ST_RUN;
                            op_d    = alu_op_t'(op);
                            work_d  = a;
                            cnt_d   = CNT_W'(b[4:0]);
                            one_d   = (b[4:0] == 5'd1);
                            msb_d   = a[WIDTH-1];
                            cf_d    = 1'b0;
                        end
                    end
                    OP_MUL: begin
                        state_d = ST_RUN;
                        op_d    = OP_MUL;
                        work_d  = a;
                        hi_d    = '0;
                        mcand_d = b;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                    default: begin
                        fin_en  = 1'b1;
                        fin_inv = 1'b1;
                    end
                endcase
            end
        end else begin
            // MUL keeps the multiplier in the working register and shifts the
            // product's low half into it from the accumulator.
            case (op_q)
                OP_SHL: begin
                    step_cf   = work_q[WIDTH-1];
                    step_work = {work_q[WIDTH-2:0], 1'b0};
                end
                OP_SHR: begin
                    step_cf   = work_q[0];
                    step_work = {1'b0, work_q[WIDTH-1:1]};
                end
                OP_SAR: begin
                    step_cf   = work_q[0];
                    step_work = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                end
                default: begin
                    mul_sum   = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
                    step_hi   = mul_sum[WIDTH:1];
                    step_work = {mul_sum[0], work_q[WIDTH-1:1]};
                end
            endcase

            work_d = step_work;
            hi_d   = step_hi;
            cf_d   = step_cf;
            cnt_d  = cnt_q - CNT_W'(1);

            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                fin_en  = 1'b1;
                fin_res = step_work;
                if (op_q == OP_MUL) begin
                    fin_hi = step_hi;
                    fin_cf = |step_hi;
                    fin_of = |step_hi;
                end else begin
                    fin_cf = step_cf;
                    if (one_q) begin
                        case (op_q)
                            OP_SHL:  fin_of = step_work[WIDTH-1] ^ step_cf;
                            OP_SHR:  fin_of = msb_q;
                            default: fin_of = 1'b0;
                        endcase
                    end
                end
            end
        end
    end

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .result_i (fin_res),
        .zf_o     (fl_zf),
        .sf_o     (fl_sf),
        .pf_o     (fl_pf)
    );

    always_comb begin
        flags_d = '0;
        if (!fin_inv) begin
            flags_d[FLAG_CF] = fin_cf;
            flags_d[FLAG_PF] = fl_pf;
            flags_d[FLAG_ZF] = fl_zf;
            flags_d[FLAG_SF] = fl_sf;
            flags_d[FLAG_OF] = fin_of;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_SELA;
            work_q    <= '0;
            hi_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            one_q     <= 1'b0;
            msb_q     <= 1'b0;
            cf_q      <= 1'b0;
            out_q     <= '0;
            out_hi_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            work_q    <= work_d;
            hi_q      <= hi_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            one_q     <= one_d;
            msb_q     <= msb_d;
            cf_q      <= cf_d;
            done_q    <= fin_en;
            invalid_q <= fin_inv;
            if (fin_en) begin
                out_q    <= fin_res;
                out_hi_q <= fin_hi;
                flags_q  <= flags_d;
            end
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign invalid = invalid_q;
    assign out     = out_q;
    assign out_hi  = out_hi_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed vectors push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 16;

    typedef struct {
        string       name;
        logic [15:0] exp_out;
        logic [15:0] exp_hi;
        logic [4:0]  exp_flags;
        logic        exp_inv;
        int          issue_cyc;
        int          exp_lat;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [ALUOP_BITS-1:0] op = '0;
    logic [W-1:0]          a = '0;
    logic [W-1:0]          b = '0;
    logic                  carry_in = 1'b0;
    logic                  busy, done, invalid;
    logic [W-1:0]          out, out_hi;
    logic [4:0]            flags;

    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];
    exp_t mon_e;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .out_hi   (out_hi),
        .flags    (flags),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_done: got done out=%h, expected no done", out);
            end else begin
                mon_e = sb.pop_front();
                $display("[TB] %s out=%h hi=%h flags=%b inv=%b lat=%0d",
                         mon_e.name, out, out_hi, flags, invalid, cyc - mon_e.issue_cyc);
                check({mon_e.name, ".out"},     32'(out),     32'(mon_e.exp_out));
                check({mon_e.name, ".out_hi"},  32'(out_hi),  32'(mon_e.exp_hi));
                check({mon_e.name, ".flags"},   32'(flags),   32'(mon_e.exp_flags));
                check({mon_e.name, ".invalid"}, 32'(invalid), 32'(mon_e.exp_inv));
                check({mon_e.name, ".latency"}, 32'(cyc - mon_e.issue_cyc), 32'(mon_e.exp_lat));
            end
        end
    end

    // Called at a negedge; drives one start cycle, then scrambles the inputs.
    task automatic issue(input string nm, input logic [3:0] op_v, input logic [15:0] a_v,
                         input logic [15:0] b_v, input logic cin, input logic [15:0] eo,
                         input logic [15:0] eh, input logic [4:0] ef, input logic einv,
                         input int lat);
        exp_t e;
        start = 1'b1;
        op = op_v;
        a = a_v;
        b = b_v;
        carry_in = cin;
        e.name = nm; e.exp_out = eo; e.exp_hi = eh; e.exp_flags = ef;
        e.exp_inv = einv; e.issue_cyc = cyc; e.exp_lat = lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~a_v;
        b = ~b_v;
        op = OP_ADD;
        carry_in = ~cin;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // flags = {OF,SF,ZF,PF,CF}
    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.busy",    32'(busy),    32'd0);
        check("rst.done",    32'(done),    32'd0);
        check("rst.invalid", 32'(invalid), 32'd0);
        check("rst.out",     32'(out),     32'd0);
        check("rst.out_hi",  32'(out_hi),  32'd0);
        check("rst.flags",   32'(flags),   32'd0);

        issue("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0, 5'b11010, 1'b0, 1);
        drain("add_ovf");
        issue("sub_brw", OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 16'h0, 5'b01011, 1'b0, 1);
        drain("sub_brw");
        issue("sbb_cin", OP_SBB, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0, 5'b01011, 1'b0, 1);
        drain("sbb_cin");
        issue("shl_n1",  OP_SHL, 16'h8001, 16'h0001, 1'b0, 16'h0002, 16'h0, 5'b10001, 1'b0, 2);
        drain("shl_n1");
        issue("shl_n0",  OP_SHL, 16'h8001, 16'h0000, 1'b0, 16'h8001, 16'h0, 5'b01000, 1'b0, 1);
        drain("shl_n0");
        issue("sar_n17", OP_SAR, 16'h8000, 16'h0011, 1'b0, 16'hFFFF, 16'h0, 5'b01011, 1'b0, 18);
        drain("sar_n17");
        issue("shr_n16", OP_SHR, 16'h8000, 16'h0010, 1'b0, 16'h0000, 16'h0, 5'b00111, 1'b0, 17);
        drain("shr_n16");

        // Back-to-back single-cycle ops: each start lands in the previous done cycle.
        issue("and",  OP_AND,  16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 16'h0, 5'b01010, 1'b0, 1);
        issue("or",   OP_OR,   16'h00FF, 16'h0F00, 1'b0, 16'h0FFF, 16'h0, 5'b00010, 1'b0, 1);
        issue("xor",  OP_XOR,  16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 16'h0, 5'b00110, 1'b0, 1);
        issue("sela", OP_SELA, 16'h1234, 16'h5678, 1'b0, 16'h1234, 16'h0, 5'b00000, 1'b0, 1);
        issue("selb", OP_SELB, 16'h1234, 16'h0080, 1'b0, 16'h0080, 16'h0, 5'b00000, 1'b0, 1);
        issue("adc",  OP_ADC,  16'h0001, 16'h0001, 1'b1, 16'h0003, 16'h0, 5'b00010, 1'b0, 1);
        drain("b2b");

        issue("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 5'b10001, 1'b0, 17);
        check("mul.busy_c1", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = OP_SELA;
        a = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        check("mul.busy_c6", 32'(busy), 32'd1);
        drain("mul_max");

        // Abort a MUL with reset at cycle 5.
        start = 1'b1;
        op = OP_MUL;
        a = 16'h1234;
        b = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort.busy_c5", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", 32'(busy),   32'd0);
        check("abort.done", 32'(done),   32'd0);
        check("abort.out",  32'(out),    32'd0);
        check("abort.hi",   32'(out_hi), 32'd0);
        check("abort.flags",32'(flags),  32'd0);
        repeat (20) @(negedge clk);

        issue("add_post", OP_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 16'h0, 5'b00000, 1'b0, 1);
        drain("add_post");
        issue("bad_op", 4'hF, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0, 5'b00000, 1'b1, 1);
        drain("bad_op");
        @(negedge clk);
        check("post.invalid", 32'(invalid), 32'd0);
        check("post.done",    32'(done),    32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
